// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging NUM_S AXI-Stream slave ports onto one master port.
// A grant is held from the first beat until the TLAST beat is accepted, so packets never interleave.
module axis_rr_arbiter #(
  parameter int NUM_S  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 1,
  parameter int TAG_ID = 0,
  localparam int KEEP_STRB_W = DATA_W / 8,
  localparam int IDX_W       = $clog2(NUM_S)
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_S-1:0]              s_tvalid,
  output logic [NUM_S-1:0]              s_tready,
  input  logic [NUM_S*DATA_W-1:0]       s_tdata,
  input  logic [NUM_S*KEEP_STRB_W-1:0]  s_tstrb,
  input  logic [NUM_S*KEEP_STRB_W-1:0]  s_tkeep,
  input  logic [NUM_S-1:0]              s_tlast,
  input  logic [NUM_S*ID_W-1:0]         s_tid,
  input  logic [NUM_S*DEST_W-1:0]       s_tdest,
  input  logic [NUM_S*USER_W-1:0]       s_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_W-1:0]             m_tdata,
  output logic [KEEP_STRB_W-1:0]        m_tstrb,
  output logic [KEEP_STRB_W-1:0]        m_tkeep,
  output logic                          m_tlast,
  output logic [ID_W-1:0]               m_tid,
  output logic [DEST_W-1:0]             m_tdest,
  output logic [USER_W-1:0]             m_tuser,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy,
  output logic [0:0]                    state_dbg
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             pick_found;
  logic             beat_acc;

  logic [DATA_W-1:0]      tdata_a [NUM_S];
  logic [KEEP_STRB_W-1:0] tstrb_a [NUM_S];
  logic [KEEP_STRB_W-1:0] tkeep_a [NUM_S];
  logic [ID_W-1:0]        tid_a   [NUM_S];
  logic [DEST_W-1:0]      tdest_a [NUM_S];
  logic [USER_W-1:0]      tuser_a [NUM_S];

  for (genvar i = 0; i < NUM_S; i++) begin : g_unpack
    assign tdata_a[i] = s_tdata[i*DATA_W +: DATA_W];
    assign tstrb_a[i] = s_tstrb[i*KEEP_STRB_W +: KEEP_STRB_W];
    assign tkeep_a[i] = s_tkeep[i*KEEP_STRB_W +: KEEP_STRB_W];
    assign tid_a[i]   = s_tid[i*ID_W +: ID_W];
    assign tdest_a[i] = s_tdest[i*DEST_W +: DEST_W];
    assign tuser_a[i] = s_tuser[i*USER_W +: USER_W];
  end

  // Search order starts one past the last port that completed a packet and wraps at NUM_S-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = rr_ptr_q;
    for (int k = 0; k < NUM_S; k++) begin
      cand = (cand == IDX_W'(NUM_S - 1)) ? '0 : cand + 1'b1;
      if (!pick_found && s_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Handshake: a beat moves when m_tvalid && m_tready on a rising ACLK edge; the granted port's
  // s_tready is m_tready combinationally, all other s_tready are 0, and IDLE never accepts data.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tstrb  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    m_tdest  = '0;
    m_tuser  = '0;
    s_tready = '0;
    if (state_q == ST_LOCK) begin
      m_tvalid = s_tvalid[grant_q];
      m_tdata  = tdata_a[grant_q];
      m_tstrb  = tstrb_a[grant_q];
      m_tkeep  = tkeep_a[grant_q];
      m_tlast  = s_tlast[grant_q];
      m_tid    = (TAG_ID != 0) ? ID_W'(grant_q) : tid_a[grant_q];
      m_tdest  = tdest_a[grant_q];
      m_tuser  = tuser_a[grant_q];
      s_tready[grant_q] = m_tready;
    end
  end

  assign beat_acc = m_tvalid && m_tready;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        // Only the accepted TLAST beat releases the grant; valid gaps on the port do not.
        if (beat_acc && m_tlast) begin
          state_d  = ST_IDLE;
          rr_ptr_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(NUM_S - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == ST_LOCK);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-port beat sources, a cycle-level grant model and an
// expected-beat scoreboard; a second instance with TAG_ID=1 checks port tagging on m_tid.
module tb_axis_rr_arbiter;

  localparam int NUM_S  = 4;
  localparam int DATA_W = 32;
  localparam int KW     = DATA_W / 8;
  localparam int ID_W   = 4;
  localparam int DEST_W = 4;
  localparam int USER_W = 1;
  localparam int IDX_W  = 2;
  localparam int SW     = DATA_W + 2;        // {bubble, last, data}
  localparam int EW     = IDX_W + 1 + DATA_W; // {port, last, data}

  logic                       ACLK = 1'b0;
  logic                       ARESET = 1'b1;
  logic [NUM_S-1:0]           s_tvalid = '0;
  logic [NUM_S*DATA_W-1:0]    s_tdata = '0;
  logic [NUM_S*KW-1:0]        s_tstrb = '0;
  logic [NUM_S*KW-1:0]        s_tkeep = '0;
  logic [NUM_S-1:0]           s_tlast = '0;
  logic [NUM_S*ID_W-1:0]      s_tid = '0;
  logic [NUM_S*DEST_W-1:0]    s_tdest = '0;
  logic [NUM_S*USER_W-1:0]    s_tuser = '0;
  logic                       m_tready = 1'b0;

  logic [NUM_S-1:0]  s_tready, t_s_tready;
  logic              m_tvalid, t_m_tvalid;
  logic [DATA_W-1:0] m_tdata, t_m_tdata;
  logic [KW-1:0]     m_tstrb, t_m_tstrb, m_tkeep, t_m_tkeep;
  logic              m_tlast, t_m_tlast;
  logic [ID_W-1:0]   m_tid, t_m_tid;
  logic [DEST_W-1:0] m_tdest, t_m_tdest;
  logic [USER_W-1:0] m_tuser, t_m_tuser;
  logic [IDX_W-1:0]  grant_idx, t_grant_idx;
  logic              busy, t_busy;
  logic [0:0]        state_dbg, t_state_dbg;

  axis_rr_arbiter #(.NUM_S(NUM_S), .DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W),
                    .USER_W(USER_W), .TAG_ID(0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .grant_idx(grant_idx), .busy(busy), .state_dbg(state_dbg)
  );

  axis_rr_arbiter #(.NUM_S(NUM_S), .DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W),
                    .USER_W(USER_W), .TAG_ID(1)) dut_tag (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_tvalid(s_tvalid), .s_tready(t_s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(t_m_tvalid), .m_tready(m_tready), .m_tdata(t_m_tdata), .m_tstrb(t_m_tstrb),
    .m_tkeep(t_m_tkeep), .m_tlast(t_m_tlast), .m_tid(t_m_tid), .m_tdest(t_m_tdest),
    .m_tuser(t_m_tuser), .grant_idx(t_grant_idx), .busy(t_busy), .state_dbg(t_state_dbg)
  );

  // ---------------- clock / reset control ----------------
  initial forever #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [SW-1:0] src_q [NUM_S][$];
  logic [EW-1:0] exp_q [$];

  bit rst_req   = 1'b1;
  bit all_valid = 1'b0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
  bit tog = 1'b1;
  int beats_acc = 0;

  // grant model
  bit m_known = 1'b0;
  bit m_state = 1'b0;
  int m_grant = 0;
  int m_rr    = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_beats(input int p, input int n, input logic [DATA_W-1:0] base,
                            input bit fin, input bit rnd);
    logic [DATA_W-1:0] d;
    logic lst;
    for (int b = 0; b < n; b++) begin
      d   = rnd ? DATA_W'($urandom) : base + DATA_W'(b);
      lst = fin && (b == n - 1);
      src_q[p].push_back({1'b0, lst, d});
      exp_q.push_back({IDX_W'(p), lst, d});
    end
  endtask

  task automatic add_gap(input int p, input int n);
    for (int b = 0; b < n; b++) src_q[p].push_back({1'b1, 1'b0, DATA_W'(0)});
  endtask

  function automatic bit sources_busy();
    bit r = 1'b0;
    for (int p = 0; p < NUM_S; p++) if (src_q[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, advance model and scoreboard.
  task automatic step();
    logic [DATA_W-1:0] d;
    logic [EW-1:0] e;
    logic [NUM_S-1:0] er;
    logic [NUM_S-1:0] bub;
    logic lst, acc, exp_mv;
    int ep;

    @(negedge ACLK);
    ARESET = rst_req;
    bub = '0;
    for (int p = 0; p < NUM_S; p++) begin
      d = '0;
      lst = 1'b0;
      s_tvalid[p] = 1'b0;
      if (all_valid) begin
        s_tvalid[p] = 1'b1;
      end else if (src_q[p].size() > 0) begin
        if (src_q[p][0][SW-1]) bub[p] = 1'b1;
        else begin
          s_tvalid[p] = 1'b1;
          d   = src_q[p][0][DATA_W-1:0];
          lst = src_q[p][0][DATA_W];
        end
      end
      s_tdata[p*DATA_W +: DATA_W] = d;
      s_tkeep[p*KW +: KW]         = d[3:0];
      s_tstrb[p*KW +: KW]         = d[7:4];
      s_tdest[p*DEST_W +: DEST_W] = d[11:8];
      s_tuser[p*USER_W +: USER_W] = d[12];
      s_tlast[p]                  = lst;
      s_tid[p*ID_W +: ID_W]       = ID_W'(p + 8);
    end
    if (rst_req) m_tready = 1'b0;
    else if (ready_mode == 1) begin
      m_tready = tog;
      tog = ~tog;
    end else if (ready_mode == 2) m_tready = ($urandom_range(0, 3) != 0);
    else m_tready = 1'b1;

    #1;
    exp_mv = m_state ? s_tvalid[m_grant] : 1'b0;
    er = '0;
    if (m_state) er[m_grant] = m_tready;
    if (m_known) begin
      check_eq("busy", 64'(busy), 64'(m_state));
      check_eq("state_dbg", 64'(state_dbg), 64'(m_state));
      check_eq("grant_idx", 64'(grant_idx), 64'(m_grant));
      check_eq("m_tvalid", 64'(m_tvalid), 64'(exp_mv));
      check_eq("s_tready", 64'(s_tready), 64'(er));
      check_eq("tag_busy", 64'(t_busy), 64'(m_state));
      check_eq("tag_s_tready", 64'(t_s_tready), 64'(er));
      if (!m_state) begin
        check_eq("idle_tdata", 64'(m_tdata), 64'(0));
        check_eq("idle_tlast", 64'(m_tlast), 64'(0));
      end
    end

    acc = m_known && m_state && exp_mv && m_tready && !rst_req;
    lst = 1'b0;
    if (acc) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 64'(1), 64'(0));
      end else begin
        e  = exp_q.pop_front();
        ep = int'(e[EW-1 -: IDX_W]);
        d  = e[DATA_W-1:0];
        check_eq("beat_port", 64'(grant_idx), 64'(ep));
        check_eq("m_tdata", 64'(m_tdata), 64'(d));
        check_eq("m_tlast", 64'(m_tlast), 64'(e[DATA_W]));
        check_eq("m_tkeep", 64'(m_tkeep), 64'(d[3:0]));
        check_eq("m_tstrb", 64'(m_tstrb), 64'(d[7:4]));
        check_eq("m_tdest", 64'(m_tdest), 64'(d[11:8]));
        check_eq("m_tuser", 64'(m_tuser), 64'(d[12]));
        check_eq("m_tid_pass", 64'(m_tid), 64'(ep + 8));
        check_eq("m_tid_tag", 64'(t_m_tid), 64'(ep));
        check_eq("tag_tdata", 64'(t_m_tdata), 64'(d));
      end
      lst = src_q[m_grant][0][DATA_W];
      void'(src_q[m_grant].pop_front());
      beats_acc++;
    end
    for (int p = 0; p < NUM_S; p++) if (bub[p]) void'(src_q[p].pop_front());

    if (rst_req) begin
      m_known = 1'b1;
      m_state = 1'b0;
      m_grant = 0;
      m_rr    = NUM_S - 1;
    end else if (m_known) begin
      if (!m_state) begin
        for (int k = 1; k <= NUM_S; k++) begin
          if (!m_state && s_tvalid[(m_rr + k) % NUM_S]) begin
            m_state = 1'b1;
            m_grant = (m_rr + k) % NUM_S;
          end
        end
      end else if (acc && lst) begin
        m_state = 1'b0;
        m_rr    = m_grant;
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() > 0 || sources_busy()) && n < max_cycles) begin
      step();
      n++;
    end
    check_eq("drain_left", 64'(exp_q.size()), 64'(0));
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int n;

    // reset with every port requesting
    rst_req = 1'b1;
    all_valid = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    all_valid = 1'b0;
    step();

    // round-robin order from reset, then port 0 again
    for (int p = 0; p < NUM_S; p++) push_beats(p, 3, DATA_W'(32'h100 * (p + 1)), 1'b1, 1'b0);
    drain(200);
    push_beats(0, 2, 32'h0000_0900, 1'b1, 1'b0);
    drain(50);

    // grant held across a valid gap while another port requests
    push_beats(1, 1, 32'h0000_1010, 1'b0, 1'b0);
    add_gap(1, 2);
    push_beats(1, 2, 32'h0000_1011, 1'b1, 1'b0);
    step();
    step();
    push_beats(0, 3, 32'h0000_2020, 1'b1, 1'b0);
    drain(100);

    // master backpressure toggling 1010..
    ready_mode = 1;
    tog = 1'b1;
    push_beats(2, 4, 32'h0000_00A0, 1'b1, 1'b0);
    drain(100);
    ready_mode = 0;

    // wrap from rr_ptr=3: port 0 beats port 3
    push_beats(3, 1, 32'h0000_3030, 1'b1, 1'b0);
    drain(50);
    push_beats(0, 2, 32'h0000_4050, 1'b1, 1'b0);
    push_beats(3, 2, 32'h0000_4053, 1'b1, 1'b0);
    drain(100);

    // reset mid-packet after two accepted beats
    push_beats(2, 5, 32'h0000_5060, 1'b1, 1'b0);
    start = beats_acc;
    n = 0;
    while (beats_acc - start < 2 && n < 50) begin
      step();
      n++;
    end
    check_eq("mid_pkt_beats", 64'(beats_acc - start), 64'(2));
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    for (int p = 0; p < NUM_S; p++) src_q[p].delete();
    exp_q.delete();

    // fresh arbitration with random lengths and random backpressure
    ready_mode = 2;
    for (int p = 0; p < NUM_S; p++)
      push_beats(p, (p == 1) ? 1 : int'($urandom_range(1, 4)), '0, 1'b1, 1'b1);
    drain(400);
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NUM_S; p++)
        push_beats(p, int'($urandom_range(1, 5)), '0, 1'b1, 1'b1);
    drain(1000);
    ready_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
